apb_uart_rx: RTL and testbench
==============================

Name: apb_uart_rx

Overview:
- APB-slave UART receiver; the receive-side companion of the APB UART transmitter on the same peripheral bus.
- Deserialises 8N1 frames from the RX pin using a programmable clocks-per-bit divisor.
- Buffers received bytes in a small FIFO and exposes data, status and sticky error flags to firmware over APB.

Parameters:
- FIFO_DEPTH, 4: receive FIFO entries; power of two, 2..16.
- RESET_COUNT_LIMIT, 50: reset value of COUNT_LIMIT (PCLK cycles per bit).

Ports:
- PCLK  in  1  sole clock.
- PRESETN  in  1  asynchronous active-low reset.
- PADDR  in  8  APB address.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data.
- PREADY  out  1  tied 1; no wait states.
- PSLVERR  out  1  tied 0.
- RX  in  1  asynchronous serial input; idle high.
- RX_IRQ  out  1  level interrupt: FIFO non-empty, or any sticky error set.

Behaviour:
- All state is clocked on PCLK. PRESETN low asynchronously clears the FSM to IDLE, empties the FIFO, clears CONFIG and the error flags, loads COUNT_LIMIT = RESET_COUNT_LIMIT and forces the synchroniser flops high. PRDATA and RX_IRQ reset to 0.
- Register map:
  - 0x00 CONFIG, R/W. Bit0 = RX_EN. Bit1 = FLUSH: write-only, self-clearing, empties the FIFO next cycle, reads back 0.
  - 0x04 RX_DATA, RO. Returns the FIFO head, or 0x00 when empty. A read access pops one entry; reading an empty FIFO does not pop.
  - 0x08 STATUS. Bit0 = DATA_VALID (FIFO not empty). Bit1 = FIFO_FULL. Bit2 = OVERRUN (sticky). Bit3 = FRAME_ERR (sticky). Bit4 = BUSY (FSM not IDLE). Bit5 = PARITY_ERR (sticky; only with the optional feature). Writing 1 clears the corresponding sticky bit; writing 0 has no effect.
  - 0x0C COUNT_LIMIT, R/W, 8 bits. Values below 2 behave as 2.
  - Unmapped addresses read 0x00; writes to them are ignored.
- APB:
  - Write commits on the PCLK edge where PSEL & PENABLE & PWRITE.
  - PRDATA is combinational from PADDR while PSEL is high, otherwise 0.
  - A pop occurs on the edge where PSEL & PENABLE & !PWRITE & PADDR==0x04.
- RX path: two-flop synchroniser on RX. Edge detection and sampling use the synchronised value only, giving 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when RX_EN=1 and a synchronised 1->0 edge is seen, go to START and load the bit counter with COUNT_LIMIT/2 (floor).
  - START: when the counter expires, sample. Sample 1 = glitch: return to IDLE with no flag. Sample 0: go to DATA, counter = COUNT_LIMIT.
  - DATA: sample 8 bits LSB first, one every COUNT_LIMIT cycles. The 3-bit index wraps 7 -> STOP.
  - STOP: sample after COUNT_LIMIT cycles.
    - Sample 1: push the byte and return to IDLE.
    - Sample 0: set FRAME_ERR, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until the synchronised RX is 1, then IDLE.
- Push onto a full FIFO drops the new byte and sets OVERRUN; existing contents are kept.
- Push and pop on the same edge with the FIFO full: both succeed, occupancy is unchanged and OVERRUN is not set.
- FLUSH and push on the same edge: flush wins and the FIFO ends empty.
- RX_EN cleared mid-frame: FSM returns to IDLE next edge and the partial byte is discarded. FIFO and flags are retained.
- COUNT_LIMIT written mid-frame: takes effect at the next counter reload.
- Error-flag set and W1C on the same edge: set wins.
- Push-to-DATA_VALID latency: 1 cycle after the stop-bit sample edge.

Optional Feature:
- Macro APB_UART_RX_PARITY_EN.
- Defined:
  - CONFIG bit2 = PAR_EN, bit3 = PAR_ODD.
  - When PAR_EN=1, a PARITY state sits between DATA and STOP and samples one bit.
  - On a mismatch, PARITY_ERR is set but the byte is still pushed.
  - STATUS bit5 is live.
- Undefined: no PARITY state; CONFIG bits 2-3 and STATUS bit5 read 0 and writes to them are ignored.

Decomposition:
- Package apb_uart_rx_pkg holds:
  - register address constants (0x00/0x04/0x08/0x0C);
  - CONFIG and STATUS bit-index constants;
  - FSM state typedef;
  - RESET_COUNT_LIMIT default.
- One sub-module, uart_rx_fifo: synchronous FIFO with FIFO_DEPTH entries, push/pop/flush inputs, full/empty outputs, and pointers one bit wider than log2(FIFO_DEPTH).

Test Plan:
- COUNT_LIMIT=16, RX_EN=1, send 0xA5 8N1 -> STATUS=0x01, RX_DATA reads 0xA5, then STATUS=0x00 and RX_IRQ=0.
- Send 5 bytes 0x01..0x05 without reading (FIFO_DEPTH=4) -> STATUS bits 0, 1, 2 set; reads return 0x01..0x04; writing 0x04 to STATUS clears OVERRUN.
- Frame 0x3C with stop bit 0 -> FRAME_ERR=1, FIFO stays empty, BUSY held until RX returns high.
- RX low pulse of 4 cycles, COUNT_LIMIT=16 -> no byte, no flags, FSM back in IDLE.
- Clear RX_EN after the 3rd data bit of a frame -> BUSY=0 within 1 cycle, no push; the next full frame 0x7E is received correctly.
- With APB_UART_RX_PARITY_EN, PAR_EN=1, PAR_ODD=0, send 0x03 with parity bit 1 -> PARITY_ERR=1 and RX_DATA=0x03.

Source files
------------

// File: rtl/apb_uart_rx_pkg.sv
// apb_uart_rx_pkg: shared constants and types for the APB UART receiver.
// Holds the register map, CONFIG/STATUS bit positions, the receive FSM state
// type and the default reset value of COUNT_LIMIT.
package apb_uart_rx_pkg;

  localparam int unsigned DATA_W = 8;

  // Register map
  localparam logic [7:0] ADDR_CONFIG      = 8'h00;
  localparam logic [7:0] ADDR_RX_DATA     = 8'h04;
  localparam logic [7:0] ADDR_STATUS      = 8'h08;
  localparam logic [7:0] ADDR_COUNT_LIMIT = 8'h0C;

  // CONFIG bit indices
  localparam int unsigned CFG_RX_EN   = 0;
  localparam int unsigned CFG_FLUSH   = 1;
  localparam int unsigned CFG_PAR_EN  = 2;
  localparam int unsigned CFG_PAR_ODD = 3;

  // STATUS bit indices
  localparam int unsigned ST_DATA_VALID = 0;
  localparam int unsigned ST_FIFO_FULL  = 1;
  localparam int unsigned ST_OVERRUN    = 2;
  localparam int unsigned ST_FRAME_ERR  = 3;
  localparam int unsigned ST_BUSY       = 4;
  localparam int unsigned ST_PARITY_ERR = 5;

  localparam int unsigned DEF_RESET_COUNT_LIMIT = 50;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_t;

  // Divisors below 2 would leave no room for a half-bit start delay.
  function automatic logic [7:0] eff_limit(input logic [7:0] lim);
    return (lim < 8'd2) ? 8'd2 : lim;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous receive FIFO with FIFO_DEPTH entries.
// Ports: clk, rst_n (async active-low), push/pop/flush strobes, wdata in,
// rdata_c (head, combinational), full_c/empty_c (decoded from pointers).
// Pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo
  import apb_uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  output logic              full_c,
  output logic              empty_c
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wptr_q;
  logic [AW:0]       rptr_q;
  logic              do_push_c;
  logic              do_pop_c;

  assign empty_c   = (wptr_q == rptr_q);
  assign full_c    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop_c  = pop & ~empty_c;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push_c = push & (~full_c | do_pop_c);
  assign rdata_c   = mem[rptr_q[AW-1:0]];

  // Pointer update; flush overrides any simultaneous push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push_c) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop_c)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (do_push_c && !flush) mem[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/apb_uart_rx.sv
// apb_uart_rx: APB slave UART receiver (8N1, programmable clocks-per-bit).
// Ports: PCLK/PRESETN clock and async active-low reset; APB slave PADDR,
// PSEL, PENABLE, PWRITE, PWDATA, PRDATA, PREADY (tied 1), PSLVERR (tied 0);
// RX serial input (idle high); RX_IRQ level interrupt (data or error).
// Optional parity checking is built when APB_UART_RX_PARITY_EN is defined.
module apb_uart_rx
  import apb_uart_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH        = 4,
  parameter int unsigned RESET_COUNT_LIMIT = DEF_RESET_COUNT_LIMIT
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic [7:0] PADDR,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic       RX,
  output logic       RX_IRQ
);

  logic       rx_meta, rx_sync, rx_prev;
  logic       rx_en_q;
  logic [7:0] count_limit_q;
  logic       overrun_q, frame_err_q, rx_irq_q;
`ifdef APB_UART_RX_PARITY_EN
  logic       par_en_q, par_odd_q, parity_err_q, parity_set_c;
`endif

  rx_state_t  state_q, state_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic [2:0] idx_q, idx_nxt;
  logic [7:0] shreg_q, shreg_nxt;
  logic       push_c, frame_set_c, overrun_set_c;
  logic       sample_c;
  logic [7:0] lim_c;

  logic       wr_c, wr_cfg_c, wr_sts_c, wr_cl_c, pop_c, flush_c;
  logic [7:0] fifo_rdata_c;
  logic       fifo_full_c, fifo_empty_c;

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign RX_IRQ  = rx_irq_q;

  // APB access decode
  assign wr_c          = PSEL & PENABLE & PWRITE;
  assign wr_cfg_c      = wr_c && (PADDR == ADDR_CONFIG);
  assign wr_sts_c      = wr_c && (PADDR == ADDR_STATUS);
  assign wr_cl_c       = wr_c && (PADDR == ADDR_COUNT_LIMIT);
  assign pop_c         = PSEL & PENABLE & ~PWRITE & (PADDR == ADDR_RX_DATA);
  assign flush_c       = wr_cfg_c & PWDATA[CFG_FLUSH];
  assign overrun_set_c = push_c & fifo_full_c & ~pop_c;

  assign lim_c    = eff_limit(count_limit_q);
  assign sample_c = (cnt_q == 8'd1);

  // RX synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      idx_q   <= idx_nxt;
      shreg_q <= shreg_nxt;
    end
  end

  // Next-state: counter of cycles to the next sample point, reloaded per bit
  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    idx_nxt     = idx_q;
    shreg_nxt   = shreg_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
`ifdef APB_UART_RX_PARITY_EN
    parity_set_c = 1'b0;
`endif
    if (!sample_c) cnt_nxt = cnt_q - 8'd1;
    case (state_q)
      S_IDLE: begin
        if (rx_en_q && rx_prev && !rx_sync) begin
          state_nxt = S_START;
          cnt_nxt   = lim_c >> 1;
        end
      end
      S_START: begin
        if (sample_c) begin
          if (rx_sync) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            cnt_nxt   = lim_c;
            idx_nxt   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (sample_c) begin
          shreg_nxt = {rx_sync, shreg_q[7:1]};
          cnt_nxt   = lim_c;
          idx_nxt   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef APB_UART_RX_PARITY_EN
            state_nxt = par_en_q ? S_PARITY : S_STOP;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef APB_UART_RX_PARITY_EN
      S_PARITY: begin
        if (sample_c) begin
          parity_set_c = rx_sync != ((^shreg_q) ^ par_odd_q);
          cnt_nxt      = lim_c;
          state_nxt    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (sample_c) begin
          if (rx_sync) begin
            push_c    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            frame_set_c = 1'b1;
            state_nxt   = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_sync) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Disabling the receiver abandons any frame in flight.
    if (!rx_en_q) begin
      state_nxt   = S_IDLE;
      push_c      = 1'b0;
      frame_set_c = 1'b0;
`ifdef APB_UART_RX_PARITY_EN
      parity_set_c = 1'b0;
`endif
    end
  end

  // Control/status registers; a flag being set beats a same-edge W1C
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_en_q       <= 1'b0;
      count_limit_q <= 8'(RESET_COUNT_LIMIT);
      overrun_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_irq_q      <= 1'b0;
`ifdef APB_UART_RX_PARITY_EN
      par_en_q      <= 1'b0;
      par_odd_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      if (wr_cfg_c) begin
        rx_en_q   <= PWDATA[CFG_RX_EN];
`ifdef APB_UART_RX_PARITY_EN
        par_en_q  <= PWDATA[CFG_PAR_EN];
        par_odd_q <= PWDATA[CFG_PAR_ODD];
`endif
      end
      if (wr_cl_c) count_limit_q <= PWDATA;
      overrun_q   <= (overrun_q & ~(wr_sts_c & PWDATA[ST_OVERRUN])) | overrun_set_c;
      frame_err_q <= (frame_err_q & ~(wr_sts_c & PWDATA[ST_FRAME_ERR])) | frame_set_c;
`ifdef APB_UART_RX_PARITY_EN
      parity_err_q <= (parity_err_q & ~(wr_sts_c & PWDATA[ST_PARITY_ERR])) | parity_set_c;
      rx_irq_q     <= ~fifo_empty_c | overrun_q | frame_err_q | parity_err_q;
`else
      rx_irq_q     <= ~fifo_empty_c | overrun_q | frame_err_q;
`endif
    end
  end

  // Read mux
  always_comb begin
    PRDATA = 8'h00;
    if (PSEL) begin
      case (PADDR)
        ADDR_CONFIG: begin
          PRDATA[CFG_RX_EN]   = rx_en_q;
`ifdef APB_UART_RX_PARITY_EN
          PRDATA[CFG_PAR_EN]  = par_en_q;
          PRDATA[CFG_PAR_ODD] = par_odd_q;
`endif
        end
        ADDR_RX_DATA:     PRDATA = fifo_empty_c ? 8'h00 : fifo_rdata_c;
        ADDR_STATUS: begin
          PRDATA[ST_DATA_VALID] = ~fifo_empty_c;
          PRDATA[ST_FIFO_FULL]  = fifo_full_c;
          PRDATA[ST_OVERRUN]    = overrun_q;
          PRDATA[ST_FRAME_ERR]  = frame_err_q;
          PRDATA[ST_BUSY]       = (state_q != S_IDLE);
`ifdef APB_UART_RX_PARITY_EN
          PRDATA[ST_PARITY_ERR] = parity_err_q;
`endif
        end
        ADDR_COUNT_LIMIT: PRDATA = count_limit_q;
        default:          PRDATA = 8'h00;
      endcase
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETN),
    .push    (push_c),
    .pop     (pop_c),
    .flush   (flush_c),
    .wdata   (shreg_q),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

endmodule

// File: tb/tb_apb_uart_rx.sv
// tb_apb_uart_rx: self-checking bench for apb_uart_rx.
// Frames are bit-banged on RX; a queue-based model of the receive FIFO and
// sticky flags supplies every expected register value.
module tb_apb_uart_rx;

  localparam int unsigned DEPTH = 4;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [7:0] paddr;
  logic       psel, penable, pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic       rx;
  logic       rx_irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] mq[$];
  logic       m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0;
  int unsigned cl = 16;

  apb_uart_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .PCLK(pclk), .PRESETN(presetn), .PADDR(paddr), .PSEL(psel),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata),
    .PREADY(pready), .PSLVERR(pslverr), .RX(rx), .RX_IRQ(rx_irq)
  );

  always #5 pclk = ~pclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    #1 d = prdata;
    @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
  endtask

  function automatic logic [7:0] exp_status(input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[0] = (mq.size() != 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = m_ferr;
    s[4] = busy;
    s[5] = m_perr;
    return s;
  endfunction

  task automatic chk_status(input string tag, input logic busy);
    logic [7:0] d;
    apb_read(8'h08, d);
    check(tag, d, exp_status(busy));
  endtask

  task automatic chk_pop(input string tag);
    logic [7:0] d, e;
    apb_read(8'h04, d);
    e = (mq.size() != 0) ? mq.pop_front() : 8'h00;
    check(tag, d, e);
  endtask

  task automatic chk_irq(input string tag);
    tick(2);
    check(tag, {7'd0, rx_irq}, {7'd0, (mq.size() != 0) | m_ovr | m_ferr | m_perr});
  endtask

  // Model of a completed frame arriving at the receiver
  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic model_w1c(input logic [7:0] d);
    if (d[2]) m_ovr = 1'b0;
    if (d[3]) m_ferr = 1'b0;
`ifdef APB_UART_RX_PARITY_EN
    if (d[5]) m_perr = 1'b0;
`endif
  endtask

  // Serialise one frame; RX is left at the stop-bit level
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic has_par, input logic par_bit);
    rx = 1'b0; tick(cl);
    for (int i = 0; i < 8; i++) begin
      rx = b[i]; tick(cl);
    end
    if (has_par) begin
      rx = par_bit; tick(cl);
    end
    rx = stop_bit; tick(cl);
    tick(4);
  endtask

  initial begin
    logic [7:0] d, b, w;
    logic       ok;
    presetn = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; rx = 1'b1;
    tick(3);
    check("rst_prdata", prdata, 8'h00);
    check("rst_irq", {7'd0, rx_irq}, 8'h00);
    presetn = 1'b1;
    tick(2);
    check("pready", {7'd0, pready}, 8'h01);
    check("pslverr", {7'd0, pslverr}, 8'h00);
    apb_read(8'h00, d); check("rst_config", d, 8'h00);
    chk_status("rst_status", 1'b0);
    apb_read(8'h0C, d); check("rst_count_limit", d, 8'h32);
    apb_read(8'h10, d); check("unmapped_rd", d, 8'h00);
    apb_write(8'h10, 8'hFF);

    // Single byte
    cl = 16;
    apb_write(8'h0C, 8'd16);
    apb_write(8'h00, 8'h01);
    apb_read(8'h0C, d); check("count_limit_rd", d, 8'd16);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0); model_frame(8'hA5, 1'b1);
    chk_status("a5_status", 1'b0);
    chk_irq("a5_irq_set");
    chk_pop("a5_data");
    chk_status("a5_status_after", 1'b0);
    chk_irq("a5_irq_clr");

    // Overrun
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0, 1'b0); model_frame(8'(i), 1'b1);
    end
    chk_status("ovr_status", 1'b0);
    for (int i = 0; i < 5; i++) chk_pop("ovr_data");
    apb_write(8'h08, 8'h04); model_w1c(8'h04);
    chk_status("ovr_w1c", 1'b0);

    // Frame error: BUSY stays until RX returns high
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0); model_frame(8'h3C, 1'b0);
    tick(2 * cl);
    chk_status("ferr_busy", 1'b1);
    rx = 1'b1; tick(6);
    chk_status("ferr_idle", 1'b0);
    apb_write(8'h08, 8'h08); model_w1c(8'h08);
    chk_status("ferr_w1c", 1'b0);

    // Start-bit glitch
    rx = 1'b0; tick(4); rx = 1'b1; tick(40);
    chk_status("glitch", 1'b0);

    // Disable mid-frame, then a clean frame
    rx = 1'b0; tick(cl);
    for (int i = 0; i < 3; i++) begin rx = 1'b0; tick(cl); end
    apb_write(8'h00, 8'h00);
    chk_status("abort_busy", 1'b0);
    rx = 1'b1; tick(5);
    apb_write(8'h00, 8'h01);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0); model_frame(8'h7E, 1'b1);
    chk_status("abort_next_status", 1'b0);
    chk_pop("abort_next_data");

    // Flush
    send_frame(8'h11, 1'b1, 1'b0, 1'b0); model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0); model_frame(8'h22, 1'b1);
    chk_status("pre_flush", 1'b0);
    apb_write(8'h00, 8'h03); mq.delete();
    chk_status("flush", 1'b0);
    apb_read(8'h00, d); check("flush_rdback", d, 8'h01);
    chk_pop("flush_empty_rd");

`ifdef APB_UART_RX_PARITY_EN
    apb_write(8'h00, 8'h05);
    apb_read(8'h00, d); check("par_cfg", d, 8'h05);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1); m_perr = 1'b1; model_frame(8'h03, 1'b1);
    chk_status("par_even_err", 1'b0);
    chk_pop("par_even_data");
    apb_write(8'h08, 8'h20); model_w1c(8'h20);
    apb_write(8'h00, 8'h0D);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1); model_frame(8'h03, 1'b1);
    chk_status("par_odd_ok", 1'b0);
    chk_pop("par_odd_data");
    apb_write(8'h00, 8'h01);
`else
    apb_write(8'h00, 8'h0D);
    apb_read(8'h00, d); check("cfg_par_masked", d, 8'h01);
    apb_write(8'h00, 8'h01);
`endif

    // Randomised frames, divisors, pops and W1C writes
    for (int it = 0; it < 24; it++) begin
      cl = $urandom_range(10, 24);
      apb_write(8'h0C, 8'(cl));
      b  = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, 1'b0, 1'b0); model_frame(b, ok);
      if (!ok) begin rx = 1'b1; tick(6); end
      chk_status("rnd_status", 1'b0);
      for (int k = $urandom_range(0, 2); k > 0; k--) chk_pop("rnd_data");
      if ($urandom_range(0, 3) == 0) begin
        w = 8'($urandom);
        apb_write(8'h08, w); model_w1c(w);
        chk_status("rnd_w1c", 1'b0);
      end
      chk_irq("rnd_irq");
    end

    apb_write(8'h0C, 8'h00);
    apb_read(8'h0C, d); check("count_limit_zero", d, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
